// File: rtl/dmem_store_buffer_if.sv
// Bus bundle between the single-cycle datapath / data memory and the
// dmem_store_buffer. The slave modport is the buffer's view; the master
// modport is the view of whatever surrounds it (datapath plus memory).
interface dmem_store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Datapath side
    logic [ADDR_W-1:0] aluResult;
    logic [DATA_W-1:0] writeData;
    logic              memWrite;
    logic [DATA_W-1:0] readData;
    logic              stall;

    // Memory side
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wvalid;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wready;

    // Status
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  aluResult, writeData, memWrite, mem_rdata, mem_wready,
        output readData, stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata,
               empty, count
    );

    modport master (
        output aluResult, writeData, memWrite, mem_rdata, mem_wready,
        input  readData, stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata,
               empty, count
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store buffer on the data-memory side of a single-cycle datapath.
// Stores are queued in a DEPTH-entry circular FIFO (DEPTH a power of two,
// at least 2) and drained through a valid/ready write port; loads are
// answered combinationally, forwarding from the youngest matching queued
// store or falling through to memory. Only whole-word stores exist, so
// byte-address bits [1:0] are ignored everywhere.
//
// Optional feature, enabled by defining STORE_COALESCE_EN: a store to the
// same word as the youngest entry overwrites that entry's data instead of
// pushing, unless that entry is the head currently offered to memory.
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,   // asynchronous, active low
    dmem_store_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage: word address and data
    logic [WA_W-1:0]   buf_addr_q [DEPTH];
    logic [DATA_W-1:0] buf_data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [WA_W-1:0]   word_addr;
    logic [PTR_W-1:0]  young_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic              full;
    logic              not_empty;
    logic              coal;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              unused_byte_bits;

    assign word_addr        = bus.aluResult[ADDR_W-1:2];
    assign unused_byte_bits = ^bus.aluResult[1:0];
    assign full             = (count_q == FULL_CNT);
    assign not_empty        = (count_q != '0);
    assign young_idx        = tail_q - PTR_W'(1);

`ifdef STORE_COALESCE_EN
    // Merge into the youngest entry unless it is the head being offered,
    // whose address/data must stay stable for the handshake.
    assign coal = bus.memWrite && not_empty
               && (buf_addr_q[young_idx] == word_addr)
               && !((young_idx == head_q) && not_empty);
`else
    assign coal = 1'b0;
`endif

    // Pointer and occupancy next-state
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pop     = not_empty && bus.mem_wready;
        push    = bus.memWrite && !full && !coal;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop)  head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment only.
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign wr_en  = push || coal;
    assign wr_idx = coal ? young_idx : tail_q;

    // Entry write: new entry at tail, or overwrite of the youngest entry
    always_ff @(posedge clk) begin
        // NOTE: the entry array has no reset; occupancy alone decides which entries are meaningful.
        if (wr_en) begin
            buf_addr_q[wr_idx] <= word_addr;
            buf_data_q[wr_idx] <= bus.writeData;
        end
    end

    // Load forwarding: scan head to tail-1 so the youngest match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q)
                && (buf_addr_q[head_q + PTR_W'(i)] == word_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[head_q + PTR_W'(i)];
            end
        end
    end

    assign bus.readData   = fwd_hit ? fwd_data : bus.mem_rdata;
    assign bus.mem_raddr  = bus.aluResult;
    assign bus.stall      = reset && bus.memWrite && full && !coal;
    assign bus.mem_wvalid = not_empty;
    assign bus.mem_waddr  = {buf_addr_q[head_q], 2'b00};
    assign bus.mem_wdata  = buf_data_q[head_q];
    assign bus.empty      = !not_empty;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer. The reference model is an
// ordered queue of pending stores: loads search it youngest-first, the
// memory write port must always present its front, and acceptance/stall
// follow from its length. Memory read data is an address-derived pattern.
module tb_dmem_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] MEM_PAT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [ADDR_W-3:0] wa;
        logic [DATA_W-1:0] d;
    } entry_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    int     n_assert = 0;
    int     n_fail   = 0;
    entry_t q[$];

    dmem_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory read model: a fixed pattern of the read address
    assign bus.mem_rdata = bus.mem_raddr ^ MEM_PAT;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].wa == addr[31:2]) return q[i].d;
        return addr ^ MEM_PAT;
    endfunction

    // One clock cycle: drive, check against the model, advance the model
    task automatic step(input logic mw, input logic [31:0] addr,
                        input logic [31:0] data, input logic wr);
        bit hit;
        bit stall_e;
        bit pop_e;
        bus.memWrite   = mw;
        bus.aluResult  = addr;
        bus.writeData  = data;
        bus.mem_wready = wr;
        #1;
        hit = 1'b0;
`ifdef STORE_COALESCE_EN
        // youngest entry is the offered head when only one store is queued
        hit = mw && (q.size() > 1) && (q[q.size()-1].wa == addr[31:2]);
`endif
        stall_e = mw && (q.size() == DEPTH) && !hit;
        check("count",    32'(bus.count),      32'(q.size()));
        check("empty",    32'(bus.empty),      32'(q.size() == 0));
        check("stall",    32'(bus.stall),      32'(stall_e));
        check("wvalid",   32'(bus.mem_wvalid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("waddr", bus.mem_waddr, {q[0].wa, 2'b00});
            check("wdata", bus.mem_wdata, q[0].d);
        end
        check("readData", bus.readData, exp_read(addr));
        pop_e = (q.size() != 0) && wr;
        if (hit) q[q.size()-1].d = data;
        if (pop_e) void'(q.pop_front());
        if (mw && !hit && !stall_e) q.push_back('{wa: addr[31:2], d: data});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_count"},  32'(bus.count),      32'd0);
        check({tag, "_empty"},  32'(bus.empty),      32'd1);
        check({tag, "_wvalid"}, 32'(bus.mem_wvalid), 32'd0);
        check({tag, "_stall"},  32'(bus.stall),      32'd0);
    endtask

    initial begin
        bus.memWrite   = 1'b1;
        bus.aluResult  = 32'h0000_0100;
        bus.writeData  = 32'h0;
        bus.mem_wready = 1'b0;

        // Reset held from time zero; a store request must not stall
        #12;
        reset_checks("rst0");
        @(negedge clk);
        reset = 1'b1;

        // Idle after reset: readData falls through to memory
        step(1'b0, 32'h0000_0100, 32'h0, 1'b0);

        // Single store, forward, then drain
        step(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
        step(1'b0, 32'h0000_0010, 32'h0,         1'b0);
        step(1'b0, 32'h0000_0013, 32'h0,         1'b1);
        step(1'b0, 32'h0000_0010, 32'h0,         1'b0);

        // Fill to DEPTH, stall, then drain in order while the fifth waits
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b0);
        step(1'b1, 32'h0000_0050, 32'h5555_5555, 1'b0);
        step(1'b1, 32'h0000_0050, 32'h5555_5555, 1'b1);
        step(1'b1, 32'h0000_0050, 32'h5555_5555, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 32'h0000_0050, 32'h0, 1'b1);

        // Repeated stores to one word: youngest wins (merged when enabled)
        step(1'b1, 32'h0000_0040, 32'h0000_4040, 1'b0);
        step(1'b1, 32'h0000_0020, 32'h0000_AAAA, 1'b0);
        step(1'b1, 32'h0000_0022, 32'h0000_BBBB, 1'b0);
        step(1'b0, 32'h0000_0020, 32'h0,         1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0000_0020, 32'h0, 1'b1);

        // Simultaneous push and pop at count 2, pointers wrapping
        step(1'b1, 32'h0000_0100, 32'h0001_0000, 1'b0);
        step(1'b1, 32'h0000_0104, 32'h0001_0001, 1'b0);
        for (int i = 2; i < 12; i++)
            step(1'b1, 32'h0000_0100 + 32'(i * 4), 32'h0001_0000 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0000_0104, 32'h0, 1'b1);

        // Asynchronous reset mid-handshake discards queued stores
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h0000_0200 + 32'(i * 4), 32'hBAD0_0000 + 32'(i), 1'b0);
        bus.memWrite   = 1'b1;
        bus.mem_wready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        reset_checks("rst_async");
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0000_0200, 32'h0, 1'b1);

        // Randomized traffic over a small address window to provoke hits
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            step(1'($urandom_range(0, 99) < 55), a, $urandom,
                 1'($urandom_range(0, 99) < 45));
        end
        while (q.size() != 0)
            step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
